// File: rtl/axis_ctrl_pkt_classifier_pkg.sv
// classifier_pkg
// Shared constants and types for the Menshen control-packet classifier:
// header byte offsets, match values, FSM state and packet class enums, and
// the first-beat class decision.
package classifier_pkg;

   localparam int ETH_TYPE_OFF   = 12;
   localparam int INNER_TYPE_OFF = 16;
   localparam int IP_VER_OFF     = 18;
   localparam int IP_PROTO_OFF   = 27;
   localparam int UDP_DPORT_OFF  = 40;

   // A control header is only trusted if every byte up to the end of the
   // UDP destination port is present.
   localparam int CTRL_KEEP_BYTES = UDP_DPORT_OFF + 2;

   localparam logic [15:0] TPID_VLAN  = 16'h8100;
   localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  PROTO_UDP  = 8'h11;
   localparam logic [3:0]  IPV4_VER   = 4'd4;

   typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTRL, DROP} state_t;
   typedef enum logic [1:0] {CLS_DATA, CLS_CTRL, CLS_DROP} cls_t;

   // hdr_match: the header fields identify a control packet.
   // keep_ok:   the header bytes are all valid.
   // keep_zero: the beat carries no bytes at all.
   function automatic cls_t classify(input logic hdr_match,
                                     input logic keep_ok,
                                     input logic keep_zero);
      cls_t c;
      if (keep_zero)
         c = CLS_DROP;
      else if (hdr_match && keep_ok)
         c = CLS_CTRL;
      else if (hdr_match)
         c = CLS_DROP;
      else
         c = CLS_DATA;
      return c;
   endfunction

endpackage

// File: rtl/axis_ctrl_pkt_classifier_if.sv
// axis_ctrl_pkt_classifier_if
// AXI-Stream bundle used on the classifier input and both outputs.
//   tdata  DW     payload, byte k = tdata[8k+7:8k]
//   tkeep  DW/8   byte enables
//   tuser  UW     sideband
//   tvalid/tready/tlast  handshake and end of packet
// Modports: master drives payload/valid, slave drives ready.
interface axis_ctrl_pkt_classifier_if #(
   parameter int DW = 512,
   parameter int UW = 128
) ();
   import classifier_pkg::*;

   logic [DW-1:0]   tdata;
   logic [DW/8-1:0] tkeep;
   logic [UW-1:0]   tuser;
   logic            tvalid;
   logic            tready;
   logic            tlast;

   modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_ctrl_pkt_classifier_out_reg.sv
// axis_out_reg
// Single-entry valid/ready register stage. Loads a beat when load is high
// and holds it until the sink takes it; a drain and a load in the same cycle
// overwrite the entry with no bubble.
//   clk, rst          clock, async active-high reset
//   load              capture in_* this cycle
//   in_data/keep/user/last  beat to capture
//   m                 registered stream output (master)
module axis_out_reg
   import classifier_pkg::*;
#(
   parameter int DW = 512,
   parameter int UW = 128
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [DW-1:0]   in_data,
   input  logic [DW/8-1:0] in_keep,
   input  logic [UW-1:0]   in_user,
   input  logic            in_last,
   axis_ctrl_pkt_classifier_if.master m
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m.tvalid <= 1'b0;
         m.tdata  <= '0;
         m.tkeep  <= '0;
         m.tuser  <= '0;
         m.tlast  <= 1'b0;
      end else if (load) begin
         m.tvalid <= 1'b1;
         m.tdata  <= in_data;
         m.tkeep  <= in_keep;
         m.tuser  <= in_user;
         m.tlast  <= in_last;
      end else if (m.tready) begin
         m.tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_ctrl_pkt_classifier.sv
// axis_ctrl_pkt_classifier
// Ingress classifier in front of rmt_wrapper. The first beat of each packet
// decides its route: VLAN/IPv4/UDP packets to CTRL_UDP_PORT go to the config
// path, truncated control headers and empty beats are dropped, the rest go
// to the RMT data path. Each output has one register stage.
//   clk, areset       stream clock, async active-high reset
//   s_axis            input stream (slave)
//   m_data_axis       data path output (master)
//   m_ctrl_axis       config path output (master)
//   stat_*_pkts       per-class packet counters, saturating
// Build option: CLASSIFIER_STATS_EN implements the counters; without it the
// stat_* ports are tied to zero.
//
// state    | meaning
// IDLE     | waiting for / classifying the first beat of a packet
// FWD_DATA | forwarding remaining beats to the data path
// FWD_CTRL | forwarding remaining beats to the config path
// DROP     | discarding remaining beats of a malformed packet
module axis_ctrl_pkt_classifier
   import classifier_pkg::*;
#(
   parameter int          C_S_AXIS_DATA_WIDTH  = 512,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2,
   parameter int          CNT_WIDTH            = 32
) (
   input  logic                 clk,
   input  logic                 areset,
   axis_ctrl_pkt_classifier_if.slave  s_axis,
   axis_ctrl_pkt_classifier_if.master m_data_axis,
   axis_ctrl_pkt_classifier_if.master m_ctrl_axis,
   output logic [CNT_WIDTH-1:0] stat_data_pkts,
   output logic [CNT_WIDTH-1:0] stat_ctrl_pkts,
   output logic [CNT_WIDTH-1:0] stat_drop_pkts
);

   state_t state;
   cls_t   cls;
   cls_t   target;
   logic   hdr_match;
   logic   keep_ok;
   logic   keep_zero;
   logic   rdy;
   logic   accept;
   logic   load_data;
   logic   load_ctrl;

   assign hdr_match =
      (s_axis.tdata[8*ETH_TYPE_OFF       +: 8] == TPID_VLAN[15:8])  &&
      (s_axis.tdata[8*(ETH_TYPE_OFF+1)   +: 8] == TPID_VLAN[7:0])   &&
      (s_axis.tdata[8*INNER_TYPE_OFF     +: 8] == ETYPE_IPV4[15:8]) &&
      (s_axis.tdata[8*(INNER_TYPE_OFF+1) +: 8] == ETYPE_IPV4[7:0])  &&
      (s_axis.tdata[8*IP_VER_OFF+4       +: 4] == IPV4_VER)         &&
      (s_axis.tdata[8*IP_PROTO_OFF       +: 8] == PROTO_UDP)        &&
      (s_axis.tdata[8*UDP_DPORT_OFF      +: 8] == CTRL_UDP_PORT[15:8]) &&
      (s_axis.tdata[8*(UDP_DPORT_OFF+1)  +: 8] == CTRL_UDP_PORT[7:0]);

   assign keep_ok   = &s_axis.tkeep[CTRL_KEEP_BYTES-1:0];
   assign keep_zero = (s_axis.tkeep == '0);
   assign cls       = classify(hdr_match, keep_ok, keep_zero);

   // Ready only depends on the output the current beat would go to, so a
   // stalled data sink never blocks control traffic and vice versa.
   always_comb begin
      target = CLS_DROP;
      case (state)
         IDLE:     target = cls;
         FWD_DATA: target = CLS_DATA;
         FWD_CTRL: target = CLS_CTRL;
         default:  target = CLS_DROP;
      endcase

      rdy = 1'b1;
      case (target)
         CLS_DATA: rdy = !m_data_axis.tvalid || m_data_axis.tready;
         CLS_CTRL: rdy = !m_ctrl_axis.tvalid || m_ctrl_axis.tready;
         default:  rdy = 1'b1;
      endcase
   end

   assign s_axis.tready = !areset && rdy;
   assign accept        = s_axis.tvalid && s_axis.tready;
   assign load_data     = accept && (target == CLS_DATA);
   assign load_ctrl     = accept && (target == CLS_CTRL);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
      end else if (accept) begin
         case (state)
            IDLE: begin
               if (!s_axis.tlast) begin
                  case (cls)
                     CLS_DATA: state <= FWD_DATA;
                     CLS_CTRL: state <= FWD_CTRL;
                     default:  state <= DROP;
                  endcase
               end
            end
            default: begin
               if (s_axis.tlast)
                  state <= IDLE;
            end
         endcase
      end
   end

   axis_out_reg #(
      .DW (C_S_AXIS_DATA_WIDTH),
      .UW (C_S_AXIS_TUSER_WIDTH)
   ) u_data_reg (
      .clk     (clk),
      .rst     (areset),
      .load    (load_data),
      .in_data (s_axis.tdata),
      .in_keep (s_axis.tkeep),
      .in_user (s_axis.tuser),
      .in_last (s_axis.tlast),
      .m       (m_data_axis)
   );

   axis_out_reg #(
      .DW (C_S_AXIS_DATA_WIDTH),
      .UW (C_S_AXIS_TUSER_WIDTH)
   ) u_ctrl_reg (
      .clk     (clk),
      .rst     (areset),
      .load    (load_ctrl),
      .in_data (s_axis.tdata),
      .in_keep (s_axis.tkeep),
      .in_user (s_axis.tuser),
      .in_last (s_axis.tlast),
      .m       (m_ctrl_axis)
   );

`ifdef CLASSIFIER_STATS_EN
   logic first_accept;
   assign first_accept = accept && (state == IDLE);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         stat_data_pkts <= '0;
         stat_ctrl_pkts <= '0;
         stat_drop_pkts <= '0;
      end else if (first_accept) begin
         case (cls)
            CLS_DATA: if (~&stat_data_pkts) stat_data_pkts <= stat_data_pkts + 1'b1;
            CLS_CTRL: if (~&stat_ctrl_pkts) stat_ctrl_pkts <= stat_ctrl_pkts + 1'b1;
            default:  if (~&stat_drop_pkts) stat_drop_pkts <= stat_drop_pkts + 1'b1;
         endcase
      end
   end
`else
   assign stat_data_pkts = '0;
   assign stat_ctrl_pkts = '0;
   assign stat_drop_pkts = '0;
`endif

endmodule

// File: tb/tb_axis_ctrl_pkt_classifier.sv
module tb_axis_ctrl_pkt_classifier;
   import classifier_pkg::*;

   localparam int DW = 512;
   localparam int KW = DW / 8;
   localparam int UW = 128;
   localparam int CW = 32;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   typedef struct packed {
      beat_t       b;
      logic [31:0] cyc;
      logic        lat;
   } exp_t;

   logic clk = 1'b0;
   logic areset;
   always #5 clk = ~clk;

   axis_ctrl_pkt_classifier_if #(.DW(DW), .UW(UW)) s_if ();
   axis_ctrl_pkt_classifier_if #(.DW(DW), .UW(UW)) md_if ();
   axis_ctrl_pkt_classifier_if #(.DW(DW), .UW(UW)) mc_if ();

   logic [CW-1:0] stat_d, stat_c, stat_x;

   axis_ctrl_pkt_classifier #(
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .CTRL_UDP_PORT        (16'hF1F2),
      .CNT_WIDTH            (CW)
   ) dut (
      .clk            (clk),
      .areset         (areset),
      .s_axis         (s_if),
      .m_data_axis    (md_if),
      .m_ctrl_axis    (mc_if),
      .stat_data_pkts (stat_d),
      .stat_ctrl_pkts (stat_c),
      .stat_drop_pkts (stat_x)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   exp_t qd[$];
   exp_t qc[$];
   int   cyc = 0;
   int   exp_nd = 0, exp_nc = 0, exp_nx = 0;
   bit   dpat_en = 0;
   int   dpat_idx = 0;
   logic [3:0] dpat = 4'b1001;

   always @(posedge clk) cyc++;

   // sink readiness: data sink follows 1,0,0,1 when the pattern is enabled
   always @(negedge clk) begin
      if (dpat_en) begin
         md_if.tready = dpat[dpat_idx];
         dpat_idx     = (dpat_idx + 1) % 4;
      end else begin
         md_if.tready = 1'b1;
      end
      mc_if.tready = 1'b1;
   end

   // output monitor / scoreboard
   bit    d_stall = 0;
   beat_t d_hold;
   always begin
      beat_t cur;
      exp_t  e;
      @(negedge clk);
      #2;
      if (areset) begin
         d_stall = 0;
      end else begin
         cur = {md_if.tdata, md_if.tkeep, md_if.tuser, md_if.tlast};
         if (md_if.tvalid && !md_if.tready) begin
            if (d_stall) check("data_hold", cur, d_hold);
            d_stall = 1;
            d_hold  = cur;
         end else begin
            d_stall = 0;
         end
         if (md_if.tvalid && md_if.tready) begin
            if (qd.size() == 0) check("data_unexp", 1, 0);
            else begin
               e = qd.pop_front();
               check("data_beat", cur, e.b);
               if (e.lat) check("data_lat", cyc, e.cyc);
            end
         end
         if (mc_if.tvalid && mc_if.tready) begin
            cur = {mc_if.tdata, mc_if.tkeep, mc_if.tuser, mc_if.tlast};
            if (qc.size() == 0) check("ctrl_unexp", 1, 0);
            else begin
               e = qc.pop_front();
               check("ctrl_beat", cur, e.b);
               if (e.lat) check("ctrl_lat", cyc, e.cyc);
            end
         end
      end
   end

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom();
      return d;
   endfunction

   function automatic logic [DW-1:0] ctrl_hdr(input logic [15:0] dport);
      logic [DW-1:0] d;
      d = rnd_data();
      d[8*12 +: 8] = 8'h81;
      d[8*13 +: 8] = 8'h00;
      d[8*16 +: 8] = 8'h08;
      d[8*17 +: 8] = 8'h00;
      d[8*18 +: 8] = 8'h45;
      d[8*27 +: 8] = 8'h11;
      d[8*40 +: 8] = dport[15:8];
      d[8*41 +: 8] = dport[7:0];
      return d;
   endfunction

   function automatic beat_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last);
      beat_t b;
      b.data = d;
      b.keep = k;
      b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.last = last;
      return b;
   endfunction

   // dest: 0 data path, 1 config path, 2 dropped
   task automatic send_beat(input beat_t b, input int dest, input bit first, input cls_t c);
      bit   acc = 0;
      int   n = 0;
      exp_t e;
      @(negedge clk);
      s_if.tdata  = b.data;
      s_if.tkeep  = b.keep;
      s_if.tuser  = b.user;
      s_if.tlast  = b.last;
      s_if.tvalid = 1'b1;
      while (!acc && n < 50) begin
         #1;
         if (dest == 2) check("drop_rdy", s_if.tready, 1);
         acc = s_if.tready;
         if (acc) begin
            e.b   = b;
            e.cyc = cyc + 1;
            e.lat = (dest == 1) || !dpat_en;
            if (dest == 0) qd.push_back(e);
            if (dest == 1) qc.push_back(e);
            if (first) begin
               case (c)
                  CLS_DATA: exp_nd++;
                  CLS_CTRL: exp_nc++;
                  default:  exp_nx++;
               endcase
            end
         end
         @(posedge clk);
         if (!acc) begin
            @(negedge clk);
            n++;
         end
      end
      check("accepted", acc, 1);
   endtask

   task automatic send_pkt(input beat_t beats[$], input cls_t c);
      int dest;
      dest = (c == CLS_DATA) ? 0 : (c == CLS_CTRL) ? 1 : 2;
      foreach (beats[i]) send_beat(beats[i], dest, (i == 0), c);
   endtask

   task automatic idle_bus();
      @(negedge clk);
      s_if.tvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((qd.size() + qc.size()) != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      check("drain", qd.size() + qc.size(), 0);
   endtask

   task automatic chk_stats(input string tag);
`ifdef CLASSIFIER_STATS_EN
      check({tag, "_sd"}, stat_d, exp_nd);
      check({tag, "_sc"}, stat_c, exp_nc);
      check({tag, "_sx"}, stat_x, exp_nx);
`else
      check({tag, "_sd"}, stat_d, 0);
      check({tag, "_sc"}, stat_c, 0);
      check({tag, "_sx"}, stat_x, 0);
`endif
   endtask

   initial begin
      beat_t p[$];
      logic [KW-1:0] k_full;
      logic [KW-1:0] k_tail;
      k_full = '1;
      k_tail = 64'h0000_0000_000f_ffff;

      s_if.tvalid = 0; s_if.tlast = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0;
      md_if.tready = 1; mc_if.tready = 1;
      areset = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dvalid", md_if.tvalid, 0);
      check("rst_cvalid", mc_if.tvalid, 0);
      check("rst_sready", s_if.tready, 0);
      check("rst_ddata", md_if.tdata, 0);
      check("rst_cdata", mc_if.tdata, 0);
      chk_stats("rst");
      @(negedge clk);
      areset = 0;

      // two-beat control packet
      p = {};
      p.push_back(mk(ctrl_hdr(16'hF1F2), k_full, 0));
      p.push_back(mk(rnd_data(), k_tail, 1));
      send_pkt(p, CLS_CTRL);
      idle_bus(); drain(); chk_stats("ctrl2");

      // single-beat data packet, dport 0
      p = {};
      p.push_back(mk(ctrl_hdr(16'h0000), k_full, 1));
      send_pkt(p, CLS_DATA);
      idle_bus(); drain(); chk_stats("data1");

      // truncated control header, then an empty beat
      p = {};
      p.push_back(mk(ctrl_hdr(16'hF1F2), k_tail, 0));
      p.push_back(mk(rnd_data(), k_full, 1));
      send_pkt(p, CLS_DROP);
      p = {};
      p.push_back(mk(rnd_data(), '0, 1));
      send_pkt(p, CLS_DROP);
      idle_bus(); drain(); chk_stats("drop");

      // multi-beat data packet whose later beats look like control headers
      p = {};
      p.push_back(mk(rnd_data(), k_full, 0));
      p.push_back(mk(ctrl_hdr(16'hF1F2), k_full, 0));
      p.push_back(mk(ctrl_hdr(16'hF1F2), 64'h0000_0000_0000_00ff, 1));
      send_pkt(p, CLS_DATA);
      idle_bus(); drain(); chk_stats("data3");

      // back-to-back data then control with a stalling data sink
      dpat_en = 1; dpat_idx = 0;
      p = {};
      p.push_back(mk(rnd_data(), k_full, 0));
      p.push_back(mk(rnd_data(), k_full, 0));
      p.push_back(mk(rnd_data(), k_full, 1));
      send_pkt(p, CLS_DATA);
      p = {};
      p.push_back(mk(ctrl_hdr(16'hF1F2), k_full, 0));
      p.push_back(mk(rnd_data(), k_tail, 1));
      send_pkt(p, CLS_CTRL);
      idle_bus(); drain(); chk_stats("b2b");
      dpat_en = 0;

      // reset in the middle of a three-beat control packet
      send_beat(mk(ctrl_hdr(16'hF1F2), k_full, 0), 1, 1, CLS_CTRL);
      send_beat(mk(rnd_data(), k_full, 0), 1, 0, CLS_CTRL);
      #1;
      areset = 1;
      #1;
      check("mid_dvalid", md_if.tvalid, 0);
      check("mid_cvalid", mc_if.tvalid, 0);
      check("mid_sready", s_if.tready, 0);
      qd.delete(); qc.delete();
      exp_nd = 0; exp_nc = 0; exp_nx = 0;
      s_if.tvalid = 0;
      repeat (2) @(negedge clk);
      chk_stats("mid_rst");
      areset = 0;
      p = {};
      p.push_back(mk(ctrl_hdr(16'hF1F2), k_full, 1));
      send_pkt(p, CLS_CTRL);
      idle_bus(); drain(); chk_stats("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_ctrl_pkt_classifier.md
Name: axis_ctrl_pkt_classifier

Overview:
- Ingress stage directly upstream of rmt_wrapper. Receives the 512-bit AXI-Stream packet flow and classifies each packet from its first beat.
- Menshen control/config packets (VLAN-tagged IPv4/UDP to the control port) are steered to the config path. All other packets go to the RMT data path.
- Malformed packets are dropped.
- Each output has one registered stage, giving one cycle of latency.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, tdata width; tkeep width = /8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width, passed through unchanged.
- CTRL_UDP_PORT, 16'hF1F2, UDP destination port that marks a control packet.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  stream clock.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  512  input data; byte k = tdata[8k+7:8k], wire order.
- s_axis_tkeep  in  64  byte enables.
- s_axis_tuser  in  128  sideband.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- m_data_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  data path to rmt_wrapper.
- m_data_axis_tready  in  1
- m_ctrl_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  config path.
- m_ctrl_axis_tready  in  1
- stat_data_pkts  out  CNT_WIDTH  count of packets forwarded to the data path.
- stat_ctrl_pkts  out  CNT_WIDTH  count of packets forwarded to the config path.
- stat_drop_pkts  out  CNT_WIDTH  count of dropped packets.

Behaviour:
- Reset (async, areset=1):
  - state=IDLE, both m_*_tvalid=0, all m_* data regs 0, counters 0.
  - s_axis_tready=0 while areset is high.
- Classification is combinational on the first beat (state IDLE, s_axis_tvalid=1). A beat is CTRL when all of these hold:
  - bytes12-13 = 81 00;
  - bytes16-17 = 08 00;
  - byte18[7:4] = 4;
  - byte27 = 8'h11;
  - {byte40, byte41} = CTRL_UDP_PORT;
  - tkeep[41:0] all ones.
- A first beat is DROP when either holds:
  - tkeep == 0;
  - the beat matches CTRL on everything except the tkeep[41:0] condition (truncated control packet).
- Any other first beat is DATA.
- States:
  - IDLE: routes the beat by class. If tlast=1 on the accepted beat, the state stays IDLE. Otherwise it goes to FWD_DATA, FWD_CTRL or DROP.
  - FWD_DATA / FWD_CTRL: every accepted beat goes to the selected output. An accepted beat with tlast returns to IDLE.
  - DROP: s_axis_tready=1. Beats are discarded. An accepted beat with tlast returns to IDLE.
- Handshake:
  - s_axis_tready = !out_valid || out_ready for the targeted output, where the target is the output chosen for the current beat's class.
  - The output register loads when s_axis_tvalid && s_axis_tready.
  - out_valid is held, and data is stable, until out_ready is asserted.
  - Full throughput of 1 beat/cycle when the sink is ready. Latency is 1 cycle from input to output.
  - tdata/tkeep/tuser/tlast are copied unmodified.
- Simultaneous events: output drain and new load in the same cycle is allowed, with no bubble.
- Counters:
  - Each counter increments by 1 on the acceptance of a packet's first beat, in its class.
  - Counters saturate at all-ones and do not wrap.
- Reset mid-packet: the partial packet is abandoned and output valids are cleared. The next input beat is treated as a first beat.

Optional Feature:
- Macro: CLASSIFIER_STATS_EN.
- Defined: the three counters are implemented as described.
- Undefined: no counter flops are implemented. stat_* ports remain present and are tied to 0.

Decomposition:
- Shared package classifier_pkg:
  - byte offset constants: ETH_TYPE_OFF=12, INNER_TYPE_OFF=16, IP_VER_OFF=18, IP_PROTO_OFF=27, UDP_DPORT_OFF=40;
  - TPID_VLAN=16'h8100, ETYPE_IPV4=16'h0800, PROTO_UDP=8'h11;
  - state enum {IDLE, FWD_DATA, FWD_CTRL, DROP};
  - class enum {CLS_DATA, CLS_CTRL, CLS_DROP}.
- One sub-module, axis_out_reg: a single-entry valid/ready register stage, instantiated twice.

Test Plan:
- Two-beat packet with VLAN TPID 0x8100, IPv4, UDP dport F1F2, tkeep ffff_ffff_ffff_ffff then 0000_0000_000f_ffff, sinks ready -> both beats on m_ctrl one cycle later, identical; m_data_tvalid stays 0; stat_ctrl_pkts=1.
- Single-beat packet with dport 0x0000, tlast on beat 0, tkeep all ones -> appears on m_data after 1 cycle; state stays IDLE; stat_data_pkts=1.
- Packet with a CTRL header but tkeep=0000_0000_000f_ffff on the first beat -> no output on either port; s_axis_tready=1 throughout; stat_drop_pkts=1.
- Back-to-back data then ctrl packets with m_data_tready toggling 1,0,0,1 -> data beats held stable while stalled, no loss or reorder; the ctrl packet follows with no gap once the data packet drains.
- areset=1 in the middle of a 3-beat ctrl packet -> valids drop to 0 asynchronously; after release, the next beat (dport F1F2 header) is classified fresh and routed to m_ctrl.
- With CLASSIFIER_STATS_EN undefined, run the scenarios above -> stat_* remain 0; routing is identical.
